// File: rtl/id_ex_dm_pkg.sv
// id_ex_dm_pkg
// Shared constants for the decode / execute / data-memory slice of the
// single-cycle RV32 lab datapath.
//   ALU_*  : values driven on the 3-bit `op` select of id_ex_dm_datapath
//   OP_*   : 7-bit RV32 major opcodes (ins[6:0]) recognised by immediate decode
//   sext12 : sign-extends a 12-bit immediate field to 32 bits
package id_ex_dm_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/id_ex_dm_regfile.sv
// id_ex_dm_regfile
// 32 x 32-bit register file, two combinational read ports, one write port.
// x0 is hard-wired to zero on read and never written.
// Ports:
//   clk        in   write clock (rising edge)
//   reset      in   async active-high, clears every register
//   we         in   write enable
//   ra1, ra2   in   read addresses
//   wa         in   write address
//   wd         in   write data
//   rd1, rd2   out  read data (old value until the write edge, no bypass)
module id_ex_dm_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [32];

    // Reset has priority, so a write on the same edge as reset is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/id_ex_dm_datapath.sv
// id_ex_dm_datapath
// Decode, execute and data-memory slice of the single-cycle RV32 lab
// datapath: register file, immediate / offset decode, ALU and word memory.
// Optional feature macro: ID_EX_DM_SLT_EN (enables op 111 = signed SLT;
// without it op 111 yields z = 0 like the other unused codes).
// Parameters:
//   DM_WORDS   data-memory depth in 32-bit words (power of two)
// Ports:
//   clk, reset                 clock, async active-high register-file clear
//   ins                        current instruction
//   wd, RegWrite               register write-back data and enable
//   ALUSrc                     1: B = imm, 0: B = rd2
//   op                         ALU operation select
//   MemRead, MemWrite          data-memory read / write enables
//   rd1, rd2                   register operands
//   imm, jTarget, branch       decoded immediate and offset fields
//   z, zero                    ALU result (also memory byte address), z == 0
//   memOut                     load data (0 when MemRead is low)
module id_ex_dm_datapath
    import id_ex_dm_pkg::*;
#(
    parameter int DM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins,
    input  logic [31:0] wd,
    input  logic        RegWrite,
    input  logic        ALUSrc,
    input  logic [2:0]  op,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] imm,
    output logic [31:0] jTarget,
    output logic [31:0] branch,
    output logic [31:0] z,
    output logic        zero,
    output logic [31:0] memOut
);

    localparam int AW = $clog2(DM_WORDS);

    logic [31:0]   alu_b;
    logic [AW-1:0] dm_addr;
    logic [31:0]   mem [DM_WORDS];

    id_ex_dm_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (RegWrite),
        .ra1   (ins[19:15]),
        .ra2   (ins[24:20]),
        .wa    (ins[11:7]),
        .wd    (wd),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // Offsets are left in halfword units; the fetch stage does the shift.
    assign branch  = {{20{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8]};
    assign jTarget = {{12{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21]};

    // Anything not S/B/J decodes as an I-type immediate, including R-type,
    // whose imm value is simply ignored downstream.
    always_comb begin
        imm = sext12(ins[31:20]);
        case (ins[6:0])
            OP_STORE:                             imm = sext12({ins[31:25], ins[11:7]});
            OP_BRANCH:                            imm = branch;
            OP_JAL:                               imm = jTarget;
            OP_LOAD, OP_IMM, OP_JALR, OP_RTYPE:   imm = sext12(ins[31:20]);
            default:                              imm = sext12(ins[31:20]);
        endcase
    end

    assign alu_b = ALUSrc ? imm : rd2;

    always_comb begin
        z = '0;
        case (op)
            ALU_AND: z = rd1 & alu_b;
            ALU_OR:  z = rd1 | alu_b;
            ALU_ADD: z = rd1 + alu_b;
            ALU_SUB: z = rd1 - alu_b;
`ifdef ID_EX_DM_SLT_EN
            ALU_SLT: z = {31'd0, ($signed(rd1) < $signed(alu_b))};
`else
            ALU_SLT: z = '0;
`endif
            default: z = '0;
        endcase
    end

    assign zero = (z == 32'd0);

    // Byte address to word index; upper bits drop out so accesses wrap.
    assign dm_addr = z[AW+1:2];

    assign memOut = MemRead ? mem[dm_addr] : 32'd0;

    // Memory is not reset; a simultaneous read still sees the old word.
    always_ff @(posedge clk) begin
        if (MemWrite) begin
            mem[dm_addr] <= rd2;
        end
    end

endmodule

// File: tb/tb_id_ex_dm_datapath.sv
// tb_id_ex_dm_datapath
// Self-checking bench for id_ex_dm_datapath. Expected values are pushed to a
// scoreboard queue as stimulus is driven and popped when the outputs settle.
// Honours ID_EX_DM_SLT_EN to pick the SLT expectation.
module tb_id_ex_dm_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ins;
    logic [31:0] wd;
    logic        RegWrite;
    logic        ALUSrc;
    logic [2:0]  op;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] jTarget;
    logic [31:0] branch;
    logic [31:0] z;
    logic        zero;
    logic [31:0] memOut;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] exp_v;
    string       nm;

    id_ex_dm_datapath #(.DM_WORDS(256)) dut (
        .clk      (clk),
        .reset    (reset),
        .ins      (ins),
        .wd       (wd),
        .RegWrite (RegWrite),
        .ALUSrc   (ALUSrc),
        .op       (op),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .rd1      (rd1),
        .rd2      (rd2),
        .imm      (imm),
        .jTarget  (jTarget),
        .branch   (branch),
        .z        (z),
        .zero     (zero),
        .memOut   (memOut)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge, well away from the write edge.
    task automatic drive(input logic [31:0] i, input logic [31:0] w, input logic rw,
                         input logic asrc, input logic [2:0] o, input logic mr, input logic mw);
        ins = i; wd = w; RegWrite = rw; ALUSrc = asrc; op = o; MemRead = mr; MemWrite = mw;
    endtask

    task automatic expect_push(input string n, input logic [31:0] v);
        name_q.push_back(n);
        exp_q.push_back(v);
    endtask

    task automatic pop_next();
        nm    = name_q.pop_front();
        exp_v = exp_q.pop_front();
        total++;
    endtask

    // Passes through one rising edge and lands on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(32'h00108063, 32'h0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
        @(negedge clk);
        expect_push("reset_rd1", 32'h0);
        expect_push("reset_rd2", 32'h0);
        #1;
        pop_next();
        if (rd1 !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, rd1, exp_v); end
        pop_next();
        if (rd2 !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, rd2, exp_v); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_addi();
        drive(32'h00500093, 32'd5, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0);
        expect_push("addi_imm", 32'd5);
        expect_push("addi_z", 32'd5);
        #1;
        pop_next();
        if (imm !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, imm, exp_v); end
        pop_next();
        if (z !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, z, exp_v); end
        step();
        // addi x0,x1,0 reads x1 after the write edge
        drive(32'h00008013, 32'd0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
        expect_push("addi_x1_after_edge", 32'd5);
        #1;
        pop_next();
        if (rd1 !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, rd1, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_alu();
        // addi x2,x0,7 with write-back 7; before the edge x2 is still 0
        drive(32'h00700113, 32'd7, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0);
        step();
        drive(32'h002081B3, 32'd0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
        expect_push("add_z", 32'd12);
        expect_push("add_zero", 32'd0);
        #1;
        pop_next();
        if (z !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, z, exp_v); end
        pop_next();
        if ({31'd0, zero} !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, zero, exp_v); end
        @(negedge clk);
        op = 3'b110;
        expect_push("sub_z", 32'hFFFFFFFE);
        #1;
        pop_next();
        if (z !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, z, exp_v); end
        op = 3'b000;
        expect_push("and_z", 32'd5);
        #1;
        pop_next();
        if (z !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, z, exp_v); end
        op = 3'b001;
        expect_push("or_z", 32'd7);
        #1;
        pop_next();
        if (z !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, z, exp_v); end
        @(negedge clk);
        op = 3'b011;
        expect_push("unused_op_z", 32'd0);
        #1;
        pop_next();
        if (z !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, z, exp_v); end
        // beq x1,x1 under SUB
        drive(32'h00108063, 32'd0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0);
        expect_push("beq_equal_zero", 32'd1);
        #1;
        pop_next();
        if ({31'd0, zero} !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, zero, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_memory();
        // sw x2,8(x0)
        drive(32'h00202423, 32'd0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1);
        expect_push("sw_imm", 32'd8);
        expect_push("sw_z", 32'd8);
        #1;
        pop_next();
        if (imm !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, imm, exp_v); end
        pop_next();
        if (z !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, z, exp_v); end
        step();
        // lw x4,8(x0)
        drive(32'h00802203, 32'd0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0);
        expect_push("lw_memout", 32'd7);
        #1;
        pop_next();
        if (memOut !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, memOut, exp_v); end
        MemRead = 1'b0;
        expect_push("lw_noread_memout", 32'd0);
        #1;
        pop_next();
        if (memOut !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, memOut, exp_v); end
        @(negedge clk);
        // x6 = 0x408: one full memory depth past byte 8
        drive(32'h00000313, 32'h00000408, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0);
        step();
        drive(32'h00032003, 32'd0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0);
        expect_push("wrap_memout", 32'd7);
        #1;
        pop_next();
        if (memOut !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, memOut, exp_v); end
        @(negedge clk);
        // sw x1,8(x0) with MemRead also high: read sees the old word
        drive(32'h00102423, 32'd0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b1);
        expect_push("rw_same_cycle_old", 32'd7);
        #1;
        pop_next();
        if (memOut !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, memOut, exp_v); end
        step();
        drive(32'h00802203, 32'd0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0);
        expect_push("rw_same_cycle_new", 32'd5);
        #1;
        pop_next();
        if (memOut !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, memOut, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_offsets();
        drive(32'hFE000EE3, 32'd0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0);
        expect_push("beq_branch", 32'hFFFFFFFE);
        expect_push("beq_imm", 32'hFFFFFFFE);
        #1;
        pop_next();
        if (branch !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, branch, exp_v); end
        pop_next();
        if (imm !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, imm, exp_v); end
        drive(32'hFF9FF0EF, 32'd0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
        expect_push("jal_jtarget", 32'hFFFFFFFC);
        expect_push("jal_imm", 32'hFFFFFFFC);
        #1;
        pop_next();
        if (jTarget !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, jTarget, exp_v); end
        pop_next();
        if (imm !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, imm, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_x0();
        drive(32'h00000013, 32'hDEADBEEF, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0);
        step();
        RegWrite = 1'b0;
        expect_push("x0_stays_zero", 32'd0);
        #1;
        pop_next();
        if (rd1 !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, rd1, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_slt();
        // x5 = -1, then slti-style compare against imm 1
        drive(32'h00000293, 32'hFFFFFFFF, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0);
        step();
        drive(32'h00128013, 32'd0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0);
`ifdef ID_EX_DM_SLT_EN
        expect_push("slt_z", 32'd1);
`else
        expect_push("slt_z", 32'd0);
`endif
        #1;
        pop_next();
        if (z !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, z, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive(32'h00008013, 32'd0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
        expect_push("x1_before_reset", 32'd5);
        #1;
        pop_next();
        if (rd1 !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, rd1, exp_v); end
        reset = 1'b1;
        expect_push("x1_async_reset", 32'd0);
        #1;
        pop_next();
        if (rd1 !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, rd1, exp_v); end
        // write of x1 attempted while reset is held
        drive(32'h00900093, 32'd9, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0);
        step();
        drive(32'h00008013, 32'd0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
        reset = 1'b0;
        expect_push("write_blocked_by_reset", 32'd0);
        #1;
        pop_next();
        if (rd1 !== exp_v) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, rd1, exp_v); end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_addi();
        test_alu();
        test_memory();
        test_offsets();
        test_x0();
        test_slt();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
